uart_fifo_ctrl: RTL and testbench

- Parametrised synchronous FIFO for the UART 16550 Tx and Rx paths.
- Generalises the fixed 512-deep Tx/Rx FIFO wrappers to configurable data width, status width and depth, built in fabric registers rather than hard FIFO macros.
- Adds features the fixed wrappers lack: 16550 holding-register (non-FIFO) mode, programmable trigger level, sticky overrun, and an error-in-FIFO indication (LSR bit 7).
- One instance serves as the Tx FIFO (STAT_W=1, status tied 0) and one as the Rx FIFO.

---
 rtl/uart_16550_pkg.sv | 28 ++
 rtl/uart_fifo_ram.sv | 32 +++
 rtl/uart_fifo_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_16550_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_16550_pkg: shared widths, LSR status bit indices, clog2 helper. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_16550_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_STAT_W = 3;

    // Per-entry Rx status bit positions
    localparam int c_STAT_PE = 2;
    localparam int c_STAT_FE = 1;
    localparam int c_STAT_BI = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_fifo_ram: DEPTH x WIDTH register array, 1 write / 1 async read. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_fifo_ram
    import uart_16550_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             WBs_CLK_i,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge WBs_CLK_i) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_fifo_ctrl: 16550 Tx/Rx FIFO with holding-register mode,        |
// | trigger level, sticky overrun and error-in-FIFO tracking. Rev 1.0    |
// +----------------------------------------------------------------------+
module uart_fifo_ctrl
    import uart_16550_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int STAT_W = c_STAT_W,
    parameter int DEPTH  = 16
) (
    input  logic                    WBs_CLK_i,
    input  logic                    WBs_RST_i,
    input  logic                    fifo_en_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       push_dat_i,
    input  logic [STAT_W-1:0]       push_stat_i,
    input  logic                    pop_i,
    output logic [DATA_W-1:0]       pop_dat_o,
    output logic [STAT_W-1:0]       pop_stat_o,
    input  logic [clog2(DEPTH):0]   trig_lvl_i,
    output logic [clog2(DEPTH):0]   level_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    trig_o,
    output logic                    overrun_o,
    input  logic                    ovr_clr_i,
    output logic                    err_pend_o
);

    localparam int c_AW = clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_WW = STAT_W + DATA_W;

    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic [c_LW-1:0] r_err_cnt;
    logic            r_overrun;
    logic            r_fifo_en;

    logic [c_LW-1:0] w_cap;
    logic [c_LW-1:0] w_thr;
    logic            w_full;
    logic            w_empty;
    logic            w_flush;
    logic            w_push_acc;
    logic            w_pop_acc;
    logic            w_ovr_set;
    logic            w_push_err;
    logic            w_pop_err;
    logic [c_WW-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_dat;
    logic [STAT_W-1:0] w_rd_stat;

    assign w_cap   = r_fifo_en ? c_LW'(DEPTH) : c_LW'(1);
    assign w_full  = (r_level == w_cap);
    assign w_empty = (r_level == '0);

    // A mode change empties the FIFO, as an FCR[0] write does on a 16550
    assign w_flush    = flush_i | (fifo_en_i != r_fifo_en);
    assign w_pop_acc  = pop_i & ~w_empty & ~w_flush;
    assign w_push_acc = push_i & (~w_full | pop_i) & ~w_flush;
    assign w_ovr_set  = push_i & w_full & ~pop_i & ~w_flush;

    assign w_push_err = w_push_acc & (|push_stat_i);
    assign w_pop_err  = w_pop_acc & (|w_rd_stat);

    uart_fifo_ram #(
        .WIDTH (c_WW),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_ram (
        .WBs_CLK_i (WBs_CLK_i),
        .wr_en     (w_push_acc),
        .wr_addr   (r_wr_ptr),
        .wr_data   ({push_stat_i, push_dat_i}),
        .rd_addr   (r_rd_ptr),
        .rd_data   (w_rd_word)
    );

    assign w_rd_dat  = w_rd_word[DATA_W-1:0];
    assign w_rd_stat = w_rd_word[DATA_W +: STAT_W];

    always_comb begin
        w_thr = trig_lvl_i;
        if (w_thr == '0) begin
            w_thr = c_LW'(1);
        end
        if (w_thr > w_cap) begin
            w_thr = w_cap;
        end
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_err_cnt <= '0;
            r_overrun <= 1'b0;
            r_fifo_en <= fifo_en_i;
        end else begin
            r_fifo_en <= fifo_en_i;

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr_i) begin
                r_overrun <= 1'b0;
            end

            if (w_flush) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_level   <= '0;
                r_err_cnt <= '0;
            end else begin
                if (w_push_acc) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop_acc) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push_acc && !w_pop_acc) begin
                    r_level <= r_level + 1'b1;
                end else if (w_pop_acc && !w_push_acc) begin
                    r_level <= r_level - 1'b1;
                end
                if (w_push_err && !w_pop_err) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end else if (w_pop_err && !w_push_err) begin
                    r_err_cnt <= r_err_cnt - 1'b1;
                end
            end
        end
    end

    assign pop_dat_o  = w_empty ? '0 : w_rd_dat;
    assign pop_stat_o = w_empty ? '0 : w_rd_stat;
    assign level_o    = r_level;
    assign empty_o    = w_empty;
    assign full_o     = w_full;
    assign trig_o     = (r_level >= w_thr);
    assign overrun_o  = r_overrun;
    assign err_pend_o = (r_err_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_fifo_ctrl: directed + random stimulus against a queue model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int SW    = 3;
    localparam int LW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, fifo_en, flush, push, pop, ovr_clr;
    logic [DW-1:0] pdat;
    logic [SW-1:0] pstat;
    logic [LW-1:0] trig_lvl;
    logic [DW-1:0] pop_dat;
    logic [SW-1:0] pop_stat;
    logic [LW-1:0] level;
    logic          empty, full, trig, overrun, err_pend;

    uart_fifo_ctrl #(.DATA_W(DW), .STAT_W(SW), .DEPTH(DEPTH)) dut (
        .WBs_CLK_i   (clk),
        .WBs_RST_i   (rst_n),
        .fifo_en_i   (fifo_en),
        .flush_i     (flush),
        .push_i      (push),
        .push_dat_i  (pdat),
        .push_stat_i (pstat),
        .pop_i       (pop),
        .pop_dat_o   (pop_dat),
        .pop_stat_o  (pop_stat),
        .trig_lvl_i  (trig_lvl),
        .level_o     (level),
        .empty_o     (empty),
        .full_o      (full),
        .trig_o      (trig),
        .overrun_o   (overrun),
        .ovr_clr_i   (ovr_clr),
        .err_pend_o  (err_pend)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Reference model: the FIFO contents as a queue of {stat,data}
    logic [SW+DW-1:0] mq[$];
    bit m_ovr;
    bit m_fen;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : p_model
        int  cap;
        bit  is_full, is_empty, fl, dpop, dpush;
        if (!rst_n) begin
            mq.delete();
            m_ovr = 1'b0;
            m_fen = fifo_en;
        end else begin
            cap      = m_fen ? DEPTH : 1;
            is_full  = (mq.size() == cap);
            is_empty = (mq.size() == 0);
            fl       = flush || (fifo_en != m_fen);
            if (fl) begin
                mq.delete();
            end else begin
                dpop  = pop && !is_empty;
                dpush = push && (!is_full || dpop);
                if (dpop) void'(mq.pop_front());
                if (dpush) mq.push_back({pstat, pdat});
            end
            if (!fl && push && is_full && !pop) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
            m_fen = fifo_en;
        end
    end

    always @(negedge clk) begin : p_compare
        int cap, lvl, thr;
        bit err;
        if (chk_on) begin
            cap = m_fen ? DEPTH : 1;
            lvl = mq.size();
            thr = (trig_lvl == 0) ? 1 : int'(trig_lvl);
            if (thr > cap) thr = cap;
            err = 1'b0;
            foreach (mq[i]) if (mq[i][DW +: SW] != 0) err = 1'b1;
            cmp("level", 32'(level), 32'(lvl));
            cmp("empty", 32'(empty), 32'(lvl == 0));
            cmp("full", 32'(full), 32'(lvl == cap));
            cmp("trig", 32'(trig), 32'(lvl >= thr));
            cmp("overrun", 32'(overrun), 32'(m_ovr));
            cmp("err_pend", 32'(err_pend), 32'(err));
            cmp("pop_dat", 32'(pop_dat), (lvl == 0) ? 32'd0 : 32'(mq[0][DW-1:0]));
            cmp("pop_stat", 32'(pop_stat), (lvl == 0) ? 32'd0 : 32'(mq[0][DW +: SW]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [DW-1:0] d, input logic [SW-1:0] s);
        push = 1'b1; pdat = d; pstat = s;
        tick();
        push = 1'b0; pstat = '0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && !empty; i++) do_pop();
    endtask

    initial begin
        rst_n = 1'b0; fifo_en = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0;
        ovr_clr = 1'b0; pdat = '0; pstat = '0; trig_lvl = '0;
        tick(); tick();
        chk_on = 1'b1;
        rst_n = 1'b1;
        cmp("rst_level", 32'(level), 0);
        cmp("rst_empty", 32'(empty), 1);
        cmp("rst_full", 32'(full), 0);
        cmp("rst_ovr", 32'(overrun), 0);
        cmp("rst_dat", 32'(pop_dat), 0);
        cmp("rst_trig", 32'(trig), 0);
        cmp("rst_err", 32'(err_pend), 0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 15; i++) do_push(8'(8'h11 + i), '0);
        cmp("fill15_level", 32'(level), 15);
        cmp("fill15_full", 32'(full), 0);
        do_push(8'h20, '0);
        cmp("fill16_full", 32'(full), 1);
        do_push(8'h21, '0);
        cmp("ovf_ovr", 32'(overrun), 1);
        cmp("ovf_level", 32'(level), 16);
        for (int i = 0; i < 16; i++) begin
            cmp("drain_dat", 32'(pop_dat), 32'(8'h11 + i));
            do_pop();
        end
        cmp("drained_empty", 32'(empty), 1);
        cmp("drained_dat", 32'(pop_dat), 0);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        cmp("ovr_cleared", 32'(overrun), 0);

        // Push+pop on full and on empty FIFO
        for (int i = 0; i < 16; i++) do_push(8'(8'h30 + i), '0);
        push = 1'b1; pop = 1'b1; pdat = 8'hEE; tick(); push = 1'b0; pop = 1'b0;
        cmp("pp_full_level", 32'(level), 16);
        cmp("pp_full_ovr", 32'(overrun), 0);
        for (int i = 1; i < 16; i++) begin
            cmp("pp_dat", 32'(pop_dat), 32'(8'h30 + i));
            do_pop();
        end
        cmp("pp_new_dat", 32'(pop_dat), 32'hEE);
        do_pop();
        push = 1'b1; pop = 1'b1; pdat = 8'h77; tick(); push = 1'b0; pop = 1'b0;
        cmp("pp_empty_level", 32'(level), 1);
        cmp("pp_empty_dat", 32'(pop_dat), 32'h77);
        do_pop();

        // Holding-register mode
        fifo_en = 1'b0; tick(); tick();
        do_push(8'hA5, '0);
        cmp("hold_full", 32'(full), 1);
        do_push(8'h5A, '0);
        cmp("hold_ovr", 32'(overrun), 1);
        cmp("hold_dat", 32'(pop_dat), 32'hA5);
        do_pop();
        cmp("hold_empty", 32'(empty), 1);
        do_push(8'h42, '0);
        cmp("hold_level1", 32'(level), 1);
        fifo_en = 1'b1; tick();
        cmp("mode_flush_level", 32'(level), 0);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;

        // Trigger level
        trig_lvl = 5'd4;
        for (int i = 0; i < 3; i++) do_push(8'(i), '0);
        cmp("trig3", 32'(trig), 0);
        do_push(8'h03, '0);
        cmp("trig4", 32'(trig), 1);
        do_pop();
        cmp("trig_pop", 32'(trig), 0);
        trig_lvl = 5'd0;
        do_pop(); do_pop();
        cmp("trig0_lvl1", 32'(trig), 1);
        trig_lvl = 5'd31;
        for (int i = 0; i < 14; i++) do_push(8'(i), '0);
        cmp("trig_sat15", 32'(trig), 0);
        do_push(8'hFF, '0);
        cmp("trig_sat16", 32'(trig), 1);
        drain();
        trig_lvl = 5'd0;

        // Error-in-FIFO tracking
        do_push(8'h01, 3'b000);
        do_push(8'h02, 3'b100);
        do_push(8'h03, 3'b000);
        do_push(8'h04, 3'b001);
        cmp("err_4", 32'(err_pend), 1);
        do_pop(); do_pop();
        cmp("err_pop2", 32'(err_pend), 1);
        do_pop();
        cmp("err_pop3", 32'(err_pend), 1);
        do_pop();
        cmp("err_pop4", 32'(err_pend), 0);
        do_push(8'h05, 3'b010);
        flush = 1'b1; tick(); flush = 1'b0;
        cmp("err_flush", 32'(err_pend), 0);
        cmp("flush_level", 32'(level), 0);

        // Reset mid-operation, then set-beats-clear overrun
        for (int i = 0; i < 17; i++) do_push(8'(i), '0);
        for (int i = 0; i < 9; i++) do_pop();
        cmp("pre_rst_level", 32'(level), 7);
        cmp("pre_rst_ovr", 32'(overrun), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        cmp("mid_rst_level", 32'(level), 0);
        cmp("mid_rst_empty", 32'(empty), 1);
        cmp("mid_rst_ovr", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) do_push(8'(i), '0);
        ovr_clr = 1'b1; do_push(8'h99, '0); ovr_clr = 1'b0;
        cmp("set_beats_clr", 32'(overrun), 1);
        drain();

        // Randomized traffic checked every cycle by p_compare
        for (int c = 0; c < 4000; c++) begin
            int pp;
            pp = ((c / 250) % 3 == 0) ? 80 : ((c / 250) % 3 == 1) ? 50 : 20;
            push     = ($urandom_range(99) < pp);
            pop      = ($urandom_range(99) < 100 - pp);
            pdat     = DW'($urandom);
            pstat    = ($urandom_range(3) == 0) ? SW'($urandom) : '0;
            flush    = ($urandom_range(99) < 2);
            ovr_clr  = ($urandom_range(99) < 5);
            trig_lvl = LW'($urandom_range(31));
            if ($urandom_range(199) == 0) fifo_en = ~fifo_en;
            rst_n    = ($urandom_range(399) != 0);
            tick();
        end
        push = 1'b0; pop = 1'b0; flush = 1'b0; ovr_clr = 1'b0; rst_n = 1'b1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
